operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 180 ++++++++++++++++++
 tb/tb_operand_entry.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// operand_entry: keypad-driven entry of two signed decimal operands.
// Ports:
//   clk, rst (sync, active-low)   clock and reset
//   key_value[3:0], key_pressed   debounced key code and key-held level
//   A, B                          committed signed operands
//   temp_value                    signed value of the entry in progress
//   digit_count, neg              digits and sign flag of the current entry
//   state                         00 ENTRY_A, 01 ENTRY_B, 10 DONE
//   valid, overflow               one-cycle pulses: both committed / digit rejected
module operand_entry #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        key_value,
    input  logic                              key_pressed,
    output logic [WIDTH-1:0]                  A,
    output logic [WIDTH-1:0]                  B,
    output logic [WIDTH-1:0]                  temp_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              neg,
    output logic [1:0]                        state,
    output logic                              valid,
    output logic                              overflow
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned XW = WIDTH + 4;
    localparam logic [XW-1:0] LIM = XW'((1 << (WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        ENTRY_A = 2'b00,
        ENTRY_B = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [CW-1:0]     dc_d;
    logic              neg_d;
    logic [WIDTH-1:0]  a_d, b_d, temp_d;
    logic              valid_d, ovf_d;
    logic              key_prev_q;
    logic              key_event;
    logic              in_entry;
    logic [XW-1:0]     cand;
    logic [WIDTH-1:0]  commit;

    assign state = state_q;

    // Registered state, operands, entry and pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ENTRY_A;
            mag_q       <= '0;
            digit_count <= '0;
            neg         <= 1'b0;
            A           <= '0;
            B           <= '0;
            temp_value  <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
            // Held key across reset release must not look like a new press
            key_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            digit_count <= dc_d;
            neg         <= neg_d;
            A           <= a_d;
            B           <= b_d;
            temp_value  <= temp_d;
            valid       <= valid_d;
            overflow    <= ovf_d;
            key_prev_q  <= key_pressed;
        end
    end

    // Next-state and next-output logic, one action per key press
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        dc_d     = digit_count;
        neg_d    = neg;
        a_d      = A;
        b_d      = B;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;

        key_event = key_pressed & ~key_prev_q;
        in_entry  = (state_q == ENTRY_A) || (state_q == ENTRY_B);
        // Widened so mag*10+d never wraps before the limit compare
        cand      = {4'b0000, mag_q} * XW'(10) + XW'(key_value);
        // An empty entry commits zero even if the sign flag is set
        commit    = (digit_count == '0) ? '0 : temp_value;

        if (state_q == ILLEGAL) begin
            state_d = ENTRY_A;
            mag_d   = '0;
            dc_d    = '0;
            neg_d   = 1'b0;
        end else if (key_event) begin
            if (key_value <= 4'd9) begin
                if (state_q == DONE) begin
                    // Digit after DONE starts a fresh A entry with this digit
                    state_d = ENTRY_A;
                    neg_d   = 1'b0;
                    if (XW'(key_value) <= LIM) begin
                        mag_d = WIDTH'(key_value);
                        dc_d  = CW'(1);
                    end else begin
                        mag_d = '0;
                        dc_d  = '0;
                        ovf_d = 1'b1;
                    end
                end else if ((digit_count < CW'(MAX_DIGITS)) && (cand <= LIM)) begin
                    mag_d = WIDTH'(cand);
                    dc_d  = digit_count + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                case (key_value)
                    4'hA: begin
                        if (in_entry) begin
                            if (state_q == ENTRY_A) begin
                                a_d     = commit;
                                state_d = ENTRY_B;
                            end else begin
                                b_d     = commit;
                                state_d = DONE;
                                valid_d = 1'b1;
                            end
                            mag_d = '0;
                            dc_d  = '0;
                            neg_d = 1'b0;
                        end
                    end
                    4'hB: begin
                        if (in_entry) begin
                            neg_d = ~neg;
                        end
                    end
                    4'hC: begin
                        if (in_entry) begin
                            mag_d = '0;
                            dc_d  = '0;
                            neg_d = 1'b0;
                        end
                    end
                    4'hD: begin
                        if (in_entry) begin
                            if (digit_count != '0) begin
                                mag_d = mag_q / WIDTH'(10);
                                dc_d  = digit_count - CW'(1);
                            end else begin
                                neg_d = 1'b0;
                            end
                        end
                    end
                    4'hE: begin
                        state_d = ENTRY_A;
                        mag_d   = '0;
                        dc_d    = '0;
                        neg_d   = 1'b0;
                        a_d     = '0;
                        b_d     = '0;
                    end
                    default: begin
                    end
                endcase
            end
        end

        temp_d = neg_d ? (WIDTH'(0) - mag_d) : mag_d;
    end

endmodule

// File: tb/tb_operand_entry.sv
// Randomized self-checking bench for operand_entry against an integer model.
module tb_operand_entry;

    localparam int W  = 8;
    localparam int MD = 3;
    localparam int DW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    key_value = 4'h0;
    logic          key_pressed = 1'b0;
    logic [W-1:0]  A, B, temp_value;
    logic [DW-1:0] digit_count;
    logic          neg;
    logic [1:0]    state;
    logic          valid, overflow;

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integers)
    int m_a, m_b, m_mag, m_dc, m_neg, m_st, m_valid, m_ovf;
    int lim  = (1 << (W - 1)) - 1;
    int mask = (1 << W) - 1;

    operand_entry #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
        .A(A), .B(B), .temp_value(temp_value), .digit_count(digit_count),
        .neg(neg), .state(state), .valid(valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear_entry();
        m_mag = 0; m_dc = 0; m_neg = 0;
    endfunction

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_st = 0; m_valid = 0; m_ovf = 0;
        model_clear_entry();
    endfunction

    function automatic int signed_entry();
        return m_neg ? -m_mag : m_mag;
    endfunction

    // One key event applied to the model
    function automatic void model_key(input int k);
        int val;
        m_valid = 0; m_ovf = 0;
        if (k <= 9) begin
            if (m_st == 2) begin
                model_clear_entry();
                m_st = 0;
                if (k <= lim) begin m_mag = k; m_dc = 1; end
                else m_ovf = 1;
            end else if (m_dc < MD && m_mag * 10 + k <= lim) begin
                m_mag = m_mag * 10 + k;
                m_dc++;
            end else begin
                m_ovf = 1;
            end
        end else if (k == 14) begin
            model_reset();
        end else if (m_st != 2) begin
            case (k)
                10: begin
                    val = (m_dc == 0) ? 0 : signed_entry();
                    if (m_st == 0) begin m_a = val; m_st = 1; end
                    else begin m_b = val; m_st = 2; m_valid = 1; end
                    model_clear_entry();
                end
                11: m_neg = m_neg ? 0 : 1;
                12: model_clear_entry();
                13: begin
                    if (m_dc > 0) begin m_mag = m_mag / 10; m_dc--; end
                    else m_neg = 0;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_A"},     32'(A),           m_a & mask);
        chk({tag, "_B"},     32'(B),           m_b & mask);
        chk({tag, "_temp"},  32'(temp_value),  signed_entry() & mask);
        chk({tag, "_dc"},    32'(digit_count), m_dc);
        chk({tag, "_neg"},   32'(neg),         m_neg);
        chk({tag, "_state"}, 32'(state),       m_st);
        chk({tag, "_valid"}, 32'(valid),       m_valid);
        chk({tag, "_ovf"},   32'(overflow),    m_ovf);
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        key_value = 4'(k);
        key_pressed = 1'b1;
        @(negedge clk);
        model_key(k);
        check_all("evt");
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            m_valid = 0; m_ovf = 0;
            check_all("hold");
        end
        key_pressed = 1'b0;
        @(negedge clk);
        m_valid = 0; m_ovf = 0;
        check_all("rel");
    endtask

    task automatic do_reset(input logic held);
        @(negedge clk);
        rst = 1'b0;
        key_pressed = held;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        check_all("post_rst");
        key_pressed = 1'b0;
        @(negedge clk);
        check_all("rst_rel");
    endtask

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("init");
        rst = 1'b1;

        // 1,2,7,A -> A=127
        press(1, 1); press(2, 1); press(7, 1); press(10, 1);
        chk("d_A127", 32'(A), 32'h7F);
        chk("d_stB", 32'(state), 32'd1);
        // 1,2,8 -> third digit rejected
        press(1, 1); press(2, 1);
        @(negedge clk);
        key_value = 4'd8;
        key_pressed = 1'b1;
        @(negedge clk);
        model_key(8);
        check_all("ovf");
        chk("d_ovf_pulse", 32'(overflow), 32'd1);
        chk("d_temp12", 32'(temp_value), 32'd12);
        @(negedge clk);
        chk("d_ovf_drop", 32'(overflow), 32'd0);
        key_pressed = 1'b0;
        @(negedge clk);
        m_ovf = 0;
        check_all("ovf_rel");
        press(12, 1);
        // B,4,5,A -> B=-45, DONE, valid
        press(11, 1); press(4, 1); press(5, 1);
        @(negedge clk);
        key_value = 4'hA;
        key_pressed = 1'b1;
        @(negedge clk);
        model_key(10);
        check_all("confB");
        chk("d_B_m45", 32'(B), 32'hD3);
        chk("d_valid", 32'(valid), 32'd1);
        @(negedge clk);
        chk("d_valid_drop", 32'(valid), 32'd0);
        key_pressed = 1'b0;
        @(negedge clk);
        m_valid = 0;
        check_all("confB_rel");
        // DONE: digit restarts, clear all zeroes operands
        press(3, 1);
        chk("d_restart_temp", 32'(temp_value), 32'd3);
        chk("d_restart_B", 32'(B), 32'hD3);
        press(14, 1);
        chk("d_clrall_A", 32'(A), 32'd0);
        // Long hold -> single digit, then two backspaces
        press(7, 6);
        chk("d_hold_temp", 32'(temp_value), 32'd7);
        press(13, 1); press(13, 1);
        chk("d_bs_dc", 32'(digit_count), 32'd0);
        // Reset mid-entry with key held across release
        press(9, 1); press(9, 1);
        key_value = 4'd5;
        do_reset(1'b1);
        // Sign toggle on empty entry, confirm commits zero
        press(11, 1); press(10, 1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                key_value = 4'($urandom_range(0, 15));
                do_reset(1'($urandom_range(0, 1)));
            end else if (r < 60) begin
                press($urandom_range(0, 9), $urandom_range(1, 3));
            end else begin
                press($urandom_range(10, 15), $urandom_range(1, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
